load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, max bus wait cycles before abort (range 2..255).
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  in  1  core requests a memory access.
REQ-005 req_ready_o  out  1  unit idle, can accept a request.
REQ-006 mem_write_enable_i  in  1  1 = store, 0 = load.
REQ-007 funct3_i  in  3  access size/sign (RV32I load/store funct3).
REQ-008 addr_i  in  32  byte address.
REQ-009 store_data_i  in  32  store source (rs2), data in low bits.
REQ-010 load_data_o  out  32  extended load result, registered.
REQ-011 done_o  out  1  one-cycle pulse, access complete.
REQ-012 err_code_o  out  2  00 ok, 01 misaligned, 10 illegal funct3, 11 timeout; valid with done_o.
REQ-013 bus_valid_o  out  1  bus request.
REQ-014 bus_ready_i  in  1  bus accepts; read data valid same cycle.
REQ-015 bus_we_o  out  1  bus write.
REQ-016 bus_addr_o  out  32  word-aligned address.
REQ-017 bus_wstrb_o  out  4  byte-lane write strobes.
REQ-018 bus_wdata_o  out  32  lane-positioned write data.
REQ-019 bus_rdata_i  in  32  read word.

Function
REQ-020 States: IDLE, BUS, DONE; req_ready_o = 1 only in IDLE.
REQ-021 Accept when req_valid_i & req_ready_o; latch mem_write_enable_i, funct3_i, addr_i, store_data_i; inputs ignored outside IDLE.
REQ-022 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; others -> err 10.
REQ-023 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=00 -> err 01; illegal funct3 takes priority over misaligned.
REQ-024 Error on accept: IDLE -> DONE directly, no bus_valid_o, load_data_o unchanged.
REQ-025 Legal access: IDLE -> BUS; bus_valid_o asserted the cycle after accept.
REQ-026 In BUS: bus_valid_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o held stable until bus_valid_o & bus_ready_i.
REQ-027 bus_addr_o = {addr[31:2], 2'b00}; bus_wstrb_o = 0000 for loads.
REQ-028 Store strobes: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111.
REQ-029 Store data: SB byte replicated in all 4 lanes; SH halfword in both halves; SW unchanged.
REQ-030 Load handshake: select byte/halfword at addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend; register into load_data_o.
REQ-031 Handshake -> DONE; done_o high the cycle after handshake (min latency accept->done_o = 2 cycles).
REQ-032 Wait counter clears on entering BUS, increments each BUS cycle without bus_ready_i; at TIMEOUT_CYCLES unready cycles bus_valid_o deasserts, -> DONE, err 11, load_data_o unchanged.
REQ-033 DONE lasts exactly one cycle (done_o=1), then IDLE; new request accepted the cycle after done_o, never in the done_o cycle.
REQ-034 load_data_o holds until next successful load; stores never modify it.
REQ-035 err_code_o = 00 when done_o = 0.

Reset
REQ-036 rst_i asserted: state IDLE, counter 0, load_data_o 0, done_o 0, err_code_o 00, bus_valid_o 0, bus_we_o 0, bus_wstrb_o 0000, bus_addr_o 0, bus_wdata_o 0, req_ready_o 1, all immediately, no clock required.
REQ-037 Reset during BUS abandons the access: bus_valid_o falls asynchronously, no done_o issued.

Verification
REQ-038 LB addr 0x103, bus_rdata 0x80FF_1234, ready immediate -> bus_addr 0x100, done_o 2 cycles after accept, load_data 0xFFFF_FF80, err 00.
REQ-039 SH addr 0x202, data 0x0000_ABCD -> bus_wstrb 1100, bus_wdata 0xABCD_ABCD, bus_we 1, done_o after handshake.
REQ-040 LW addr 0x201 -> no bus_valid_o, done_o next cycle, err 01; funct3 011 -> err 10.
REQ-041 LHU addr 0x2, bus_ready_i held low 16 cycles -> bus_valid_o drops, done_o, err 11, load_data_o unchanged.
REQ-042 SW with bus_ready_i low 3 cycles -> bus signals stable 4 cycles, single handshake, done_o next cycle.
REQ-043 rst_i mid-BUS -> bus_valid_o 0 immediately, req_ready_o 1, no done_o; following LW completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and memory bus signals of the load/store unit.
interface load_store_unit_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        mem_write_enable_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [31:0] load_data_o;
    logic        done_o;
    logic [1:0]  err_code_o;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_wstrb_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;

    modport slave (
        input  req_valid_i, mem_write_enable_i, funct3_i, addr_i, store_data_i, bus_ready_i, bus_rdata_i,
        output req_ready_o, load_data_o, done_o, err_code_o, bus_valid_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o
    );

    modport master (
        output req_valid_i, mem_write_enable_i, funct3_i, addr_i, store_data_i, bus_ready_i, bus_rdata_i,
        input  req_ready_o, load_data_o, done_o, err_code_o, bus_valid_o, bus_we_o, bus_addr_o, bus_wstrb_o, bus_wdata_o
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer with alignment checks, lane steering and bus timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic clk_i,
    input logic rst_i,
    load_store_unit_if.slave lsu
);
    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        illegal;
    logic        misaligned;
    logic [1:0]  err;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ext;

    assign lsu.req_ready_o = state == IDLE;

    always_comb begin
        illegal = lsu.mem_write_enable_i ? (lsu.funct3_i[2] | (lsu.funct3_i[1:0] == 2'b11))
                                         : ((lsu.funct3_i[1:0] == 2'b11) | (lsu.funct3_i == 3'b110));
        misaligned = ((lsu.funct3_i[1:0] == 2'b01) & lsu.addr_i[0]) |
                     ((lsu.funct3_i[1:0] == 2'b10) & (|lsu.addr_i[1:0]));
        err = illegal ? 2'b10 : misaligned ? 2'b01 : 2'b00;
        strb = (lsu.funct3_i[1:0] == 2'b00) ? 4'b0001 << lsu.addr_i[1:0] :
               (lsu.funct3_i[1:0] == 2'b01) ? 4'b0011 << lsu.addr_i[1:0] : 4'b1111;
        wdata = (lsu.funct3_i[1:0] == 2'b00) ? {4{lsu.store_data_i[7:0]}} :
                (lsu.funct3_i[1:0] == 2'b01) ? {2{lsu.store_data_i[15:0]}} : lsu.store_data_i;
        rbyte = 8'(lsu.bus_rdata_i >> {off_q, 3'b000});
        rhalf = off_q[1] ? lsu.bus_rdata_i[31:16] : lsu.bus_rdata_i[15:0];
        // funct3 bit 2 selects zero extension for LBU/LHU
        ext = (f3_q[1:0] == 2'b10) ? lsu.bus_rdata_i :
              (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & rhalf[15]}}, rhalf} :
                                     {{24{~f3_q[2] & rbyte[7]}}, rbyte};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            cnt             <= '0;
            f3_q            <= '0;
            off_q           <= '0;
            lsu.load_data_o <= '0;
            lsu.done_o      <= 1'b0;
            lsu.err_code_o  <= 2'b00;
            lsu.bus_valid_o <= 1'b0;
            lsu.bus_we_o    <= 1'b0;
            lsu.bus_addr_o  <= '0;
            lsu.bus_wstrb_o <= '0;
            lsu.bus_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: if (lsu.req_valid_i) begin
                    f3_q  <= lsu.funct3_i;
                    off_q <= lsu.addr_i[1:0];
                    cnt   <= '0;
                    if (err != 2'b00) begin
                        state          <= DONE;
                        lsu.done_o     <= 1'b1;
                        lsu.err_code_o <= err;
                    end else begin
                        state           <= BUS;
                        lsu.bus_valid_o <= 1'b1;
                        lsu.bus_we_o    <= lsu.mem_write_enable_i;
                        lsu.bus_addr_o  <= {lsu.addr_i[31:2], 2'b00};
                        lsu.bus_wstrb_o <= lsu.mem_write_enable_i ? strb : 4'b0000;
                        lsu.bus_wdata_o <= wdata;
                    end
                end
                BUS: if (lsu.bus_ready_i || cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                    state           <= DONE;
                    lsu.done_o      <= 1'b1;
                    lsu.err_code_o  <= lsu.bus_ready_i ? 2'b00 : 2'b11;
                    lsu.bus_valid_o <= 1'b0;
                    lsu.bus_we_o    <= 1'b0;
                    lsu.bus_wstrb_o <= 4'b0000;
                    if (lsu.bus_ready_i && !lsu.bus_we_o) lsu.load_data_o <= ext;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: begin
                    state          <= IDLE;
                    lsu.done_o     <= 1'b0;
                    lsu.err_code_o <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of loads, stores, error paths, timeout and async reset.
module tb_load_store_unit;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   n;
    int   vcyc;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .lsu   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid_i        = 1'b1;
        bus.mem_write_enable_i = we;
        bus.funct3_i           = f3;
        bus.addr_i             = a;
        bus.store_data_i       = d;
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output int valid_cycles);
        cycles = 0;
        valid_cycles = 0;
        while (!bus.done_o && cycles < 40) begin
            if (bus.bus_valid_o) valid_cycles++;
            tick();
            cycles++;
        end
        chk("done_seen", 32'(bus.done_o), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.mem_write_enable_i = 1'b0;
        bus.funct3_i = 3'b000;
        bus.addr_i = '0;
        bus.store_data_i = '0;
        bus.bus_ready_i = 1'b1;
        bus.bus_rdata_i = 32'h80FF_1234;
        #1 rst = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rst_valid", 32'(bus.bus_valid_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_err", 32'(bus.err_code_o), 32'd0);
        chk("rst_ldata", bus.load_data_o, 32'd0);
        chk("rst_addr", bus.bus_addr_o, 32'd0);
        chk("rst_wstrb", 32'(bus.bus_wstrb_o), 32'd0);
        chk("rst_wdata", bus.bus_wdata_o, 32'd0);
        chk("rst_we", 32'(bus.bus_we_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        req(1'b0, 3'b000, 32'h103, 32'h0);
        chk("lb_valid", 32'(bus.bus_valid_o), 32'd1);
        chk("lb_addr", bus.bus_addr_o, 32'h100);
        chk("lb_wstrb", 32'(bus.bus_wstrb_o), 32'd0);
        chk("lb_busy", 32'(bus.req_ready_o), 32'd0);
        wait_done(n, vcyc);
        chk("lb_lat", 32'(n), 32'd1);
        chk("lb_data", bus.load_data_o, 32'hFFFF_FF80);
        chk("lb_err", 32'(bus.err_code_o), 32'd0);
        chk("done_noready", 32'(bus.req_ready_o), 32'd0);
        tick();
        chk("done_pulse", 32'(bus.done_o), 32'd0);
        chk("idle_ready", 32'(bus.req_ready_o), 32'd1);

        req(1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
        chk("sh_wstrb", 32'(bus.bus_wstrb_o), 32'hC);
        chk("sh_wdata", bus.bus_wdata_o, 32'hABCD_ABCD);
        chk("sh_we", 32'(bus.bus_we_o), 32'd1);
        chk("sh_addr", bus.bus_addr_o, 32'h200);
        wait_done(n, vcyc);
        chk("sh_lat", 32'(n), 32'd1);
        chk("sh_keep", bus.load_data_o, 32'hFFFF_FF80);
        tick();

        req(1'b1, 3'b000, 32'h301, 32'h0000_005A);
        chk("sb_wstrb", 32'(bus.bus_wstrb_o), 32'h2);
        chk("sb_wdata", bus.bus_wdata_o, 32'h5A5A_5A5A);
        wait_done(n, vcyc);
        tick();

        req(1'b0, 3'b010, 32'h201, 32'h0);
        chk("mis_valid", 32'(bus.bus_valid_o), 32'd0);
        chk("mis_done", 32'(bus.done_o), 32'd1);
        chk("mis_err", 32'(bus.err_code_o), 32'd1);
        tick();
        chk("mis_errclr", 32'(bus.err_code_o), 32'd0);
        req(1'b0, 3'b011, 32'h201, 32'h0);
        chk("ill_done", 32'(bus.done_o), 32'd1);
        chk("ill_err", 32'(bus.err_code_o), 32'd2);
        tick();
        req(1'b1, 3'b100, 32'h200, 32'h0);
        chk("ills_err", 32'(bus.err_code_o), 32'd2);
        chk("ills_valid", 32'(bus.bus_valid_o), 32'd0);
        chk("ill_keep", bus.load_data_o, 32'hFFFF_FF80);
        tick();

        req(1'b0, 3'b101, 32'h2, 32'h0);
        wait_done(n, vcyc);
        chk("lhu_data", bus.load_data_o, 32'h0000_80FF);
        tick();
        req(1'b0, 3'b001, 32'h2, 32'h0);
        wait_done(n, vcyc);
        chk("lh_data", bus.load_data_o, 32'hFFFF_80FF);
        tick();
        req(1'b0, 3'b100, 32'h1, 32'h0);
        wait_done(n, vcyc);
        chk("lbu_data", bus.load_data_o, 32'h0000_0012);
        tick();

        bus.bus_ready_i = 1'b0;
        bus.bus_rdata_i = 32'hDEAD_BEEF;
        req(1'b0, 3'b101, 32'h2, 32'h0);
        wait_done(n, vcyc);
        chk("tmo_vcyc", 32'(vcyc), 32'd16);
        chk("tmo_valid", 32'(bus.bus_valid_o), 32'd0);
        chk("tmo_err", 32'(bus.err_code_o), 32'd3);
        chk("tmo_keep", bus.load_data_o, 32'h0000_0012);
        tick();

        req(1'b1, 3'b010, 32'h300, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.bus_ready_i = 1'b1;
            chk("sw_valid", 32'(bus.bus_valid_o), 32'd1);
            chk("sw_addr", bus.bus_addr_o, 32'h300);
            chk("sw_wstrb", 32'(bus.bus_wstrb_o), 32'hF);
            chk("sw_wdata", bus.bus_wdata_o, 32'h1234_5678);
            chk("sw_nodone", 32'(bus.done_o), 32'd0);
            tick();
        end
        chk("sw_done", 32'(bus.done_o), 32'd1);
        chk("sw_drop", 32'(bus.bus_valid_o), 32'd0);
        chk("sw_err", 32'(bus.err_code_o), 32'd0);
        tick();

        bus.bus_ready_i = 1'b0;
        req(1'b0, 3'b010, 32'h400, 32'h0);
        chk("rb_valid", 32'(bus.bus_valid_o), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rb_valid0", 32'(bus.bus_valid_o), 32'd0);
        chk("rb_ready", 32'(bus.req_ready_o), 32'd1);
        chk("rb_done", 32'(bus.done_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rb_nodone", 32'(bus.done_o), 32'd0);
        bus.bus_ready_i = 1'b1;
        bus.bus_rdata_i = 32'hCAFE_F00D;
        req(1'b0, 3'b010, 32'h400, 32'h0);
        wait_done(n, vcyc);
        chk("rb_lw", bus.load_data_o, 32'hCAFE_F00D);
        chk("rb_err", 32'(bus.err_code_o), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
